// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e        : controller FSM states
//   fwd_sel_e         : operand source select codes
//   MD_CYCLES_DEFAULT : default execute-stage occupancy of a mul/div op
//   MD_CNT_W          : width of the mul/div occupancy counter (covers 2..63)
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MD_BUSY    = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam int MD_CYCLES_DEFAULT = 32;
  localparam int MD_CNT_W          = 6;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Combinational forwarding comparator for one source operand.
// Ports:
//   src_id    in  5  register id read by the ID-stage instruction
//   mem_wr_en in  1  MEM-stage instruction writes a register
//   mem_wr_id in  5  MEM-stage destination id
//   wb_wr_en  in  1  WB-stage instruction writes a register
//   wb_wr_id  in  5  WB-stage destination id
//   sel       out 2  FWD_RF / FWD_MEM / FWD_WB
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_id,
  input  logic       mem_wr_en,
  input  logic [4:0] mem_wr_id,
  input  logic       wb_wr_en,
  input  logic [4:0] wb_wr_id,
  output logic [1:0] sel
);

  logic src_nz;
  logic mem_hit;
  logic wb_hit;

  // r0 is hardwired to zero, so a write to it must never be forwarded.
  assign src_nz  = (src_id != 5'd0);
  assign mem_hit = src_nz && mem_wr_en && (mem_wr_id == src_id);
  assign wb_hit  = src_nz && wb_wr_en && (wb_wr_id == src_id);

  // The younger (MEM) result shadows the older (WB) one.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle mul/div
// occupancy, data-memory wait freeze, branch redirect flush and operand
// forwarding selects.
// Ports:
//   sys_clk, rst_n           clock, async active-low reset
//   id_rs, id_rt             ID-stage source ids
//   id_use_rs, id_use_rt     ID instruction reads rs / rt
//   ex_wr_en, ex_mem_to_reg  EX instruction writes a register / is a load
//   ex_wr_id, mem_wr_id      EX / MEM destination ids
//   mem_wr_en                MEM instruction writes a register
//   ex_md_start              EX instruction is mul/div
//   ex_redirect              taken branch/jump resolved in EX
//   dmem_req, dmem_ready     MEM access pending / data memory done
//   stall_if, stall_id       hold PC / hold IF-ID
//   bubble_ex, flush_id      NOP into EX / squash IF-ID
//   is_stalling              whole-pipeline freeze (gates regfile writes)
//   fwd_a, fwd_b             operand source selects
//   md_busy                  mul/div unit occupied
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_RUN        | normal issue; load-use and mul/div start detected here
// ST_LOAD_STALL | single cycle after a load-use interlock, no stall output
// ST_MD_BUSY    | mul/div occupying EX; freeze until counter reaches 0
// ST_MEM_WAIT   | data memory pending; resumes the saved state on ready
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_wr_en,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_wr_id,
  input  logic [4:0] mem_wr_id,
  input  logic       mem_wr_en,
  input  logic       ex_md_start,
  input  logic       ex_redirect,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       is_stalling,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

  hz_state_e           state_q, state_d;
  hz_state_e           saved_q, saved_d;
  hz_state_e           eff_state;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                wb_en_q;
  logic [4:0]          wb_id_q;

  logic mem_stall;
  logic md_hold;
  logic freeze;
  logic in_run;
  logic rs_hit, rt_hit;
  logic load_use;
  logic take_redirect;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // MEM_WAIT only remembers where to return; once memory is ready the
  // controller behaves as the saved state in that same cycle, so a wait of
  // N cycles costs exactly N extra freeze cycles.
  assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

  assign mem_stall = dmem_req && !dmem_ready;
  assign md_hold   = (eff_state == ST_MD_BUSY) && (md_cnt_q != '0);
  assign freeze    = mem_stall || md_hold;
  assign in_run    = (eff_state == ST_RUN);

  assign rs_hit   = id_use_rs && (id_rs == ex_wr_id);
  assign rt_hit   = id_use_rt && (id_rt == ex_wr_id);
  // A load that does not write back cannot create a dependency.
  assign load_use = in_run && ex_mem_to_reg && ex_wr_en &&
                    (ex_wr_id != 5'd0) && (rs_hit || rt_hit);

  // Redirects seen during a freeze are dropped; EX still holds the branch,
  // so it is seen again in the first unfrozen cycle.
  assign take_redirect = !freeze && ex_redirect;

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    md_cnt_d = md_cnt_q;
    if (mem_stall) begin
      state_d = ST_MEM_WAIT;
      saved_d = eff_state;
    end else if (md_hold) begin
      state_d  = ST_MD_BUSY;
      md_cnt_d = md_cnt_q - 1'b1;
    end else if (in_run && ex_md_start) begin
      state_d  = ST_MD_BUSY;
      md_cnt_d = MD_LOAD;
    end else if (load_use && !ex_redirect) begin
      state_d = ST_LOAD_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      saved_q  <= ST_RUN;
      md_cnt_q <= '0;
      wb_en_q  <= 1'b0;
      wb_id_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      md_cnt_q <= md_cnt_d;
      // WB copy advances only when the pipeline does.
      if (!freeze) begin
        wb_en_q <= mem_wr_en;
        wb_id_q <= mem_wr_id;
      end
    end
  end

  hazard_fwd_sel u_fwd_a (
    .src_id    (id_rs),
    .mem_wr_en (mem_wr_en),
    .mem_wr_id (mem_wr_id),
    .wb_wr_en  (wb_en_q),
    .wb_wr_id  (wb_id_q),
    .sel       (fwd_a_raw)
  );

  hazard_fwd_sel u_fwd_b (
    .src_id    (id_rt),
    .mem_wr_en (mem_wr_en),
    .mem_wr_id (mem_wr_id),
    .wb_wr_en  (wb_en_q),
    .wb_wr_id  (wb_id_q),
    .sel       (fwd_b_raw)
  );

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    is_stalling = rst_n && freeze;
    stall_if    = rst_n && (freeze || (load_use && !take_redirect));
    stall_id    = stall_if;
    bubble_ex   = rst_n && !freeze && (take_redirect || load_use);
    flush_id    = rst_n && take_redirect;
    md_busy     = rst_n && (eff_state == ST_MD_BUSY);
    fwd_a       = rst_n ? fwd_a_raw : FWD_RF;
    fwd_b       = rst_n ? fwd_b_raw : FWD_RF;
  end

endmodule
